// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated Hack ALU: FSM states, datapath widths
// and the control word that forces a zero result.
package alu_pkg;

  localparam int ALU_W  = 16;
  localparam int CTRL_W = 6;

  // zx=1, zy=1, f=1: 0 + 0, i.e. a constant-zero operation
  localparam logic [CTRL_W-1:0] CTRL_ZERO = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zero/negate each operand, add or AND, optionally
// negate the result. Carry out of the 16-bit add is discarded.
module hack_alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]  x,
  input  logic [ALU_W-1:0]  y,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [ALU_W-1:0]  out,
  output logic              zr,
  output logic              ng
);

  logic [ALU_W-1:0] x_z, x_n, y_z, y_n, sum, fn;

  assign x_z = ctrl[5] ? '0 : x;
  assign x_n = ctrl[4] ? ~x_z : x_z;
  assign y_z = ctrl[3] ? '0 : y;
  assign y_n = ctrl[2] ? ~y_z : y_z;
  assign sum = x_n + y_n;
  assign fn  = ctrl[1] ? sum : (x_n & y_n);
  assign out = ctrl[0] ? ~fn : fn;
  assign zr  = (out == '0);
  assign ng  = out[ALU_W-1];

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one Hack ALU among N_REQ requesters; one
// operation in flight, IDLE -> EXEC -> RESP per transaction.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][ALU_W-1:0]     req_x,
  input  logic [N_REQ-1:0][ALU_W-1:0]     req_y,
  input  logic [N_REQ-1:0][CTRL_W-1:0]    req_ctrl,
  output logic [N_REQ-1:0]                rsp_valid,
  input  logic [N_REQ-1:0]                rsp_ready,
  output logic [ALU_W-1:0]                rsp_out,
  output logic                            rsp_zr,
  output logic                            rsp_ng,
  output logic                            busy,
  output logic [$clog2(N_REQ)-1:0]        grant_id
);

  localparam int GW = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [ALU_W-1:0]  op_x_q, op_x_d;
  logic [ALU_W-1:0]  op_y_q, op_y_d;
  logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
  logic [ALU_W-1:0]  res_out_q, res_out_d;
  logic              res_zr_q, res_zr_d;
  logic              res_ng_q, res_ng_d;

  logic [ALU_W-1:0]  alu_out;
  logic              alu_zr, alu_ng;
  logic              win_found;
  logic [GW-1:0]     win_id;

  hack_alu u_hack_alu (
    .x    (op_x_q),
    .y    (op_y_q),
    .ctrl (op_ctrl_q),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  // Round-robin search starting one past the previous owner
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    op_ctrl_d    = op_ctrl_q;
    res_out_d    = res_out_q;
    res_zr_d     = res_zr_q;
    res_ng_d     = res_ng_q;
    req_ready    = '0;
    rsp_valid    = '0;

    case (state_q)
      ST_IDLE: begin
        // Gated with reset_n so nothing looks accepted while reset is held
        if (win_found && reset_n) begin
          req_ready[win_id] = 1'b1;
          op_x_d            = req_x[win_id];
          op_y_d            = req_y[win_id];
          op_ctrl_d         = req_ctrl[win_id];
          grant_id_d        = win_id;
          last_grant_d      = win_id;
          state_d           = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_out_d = alu_out;
        res_zr_d  = alu_zr;
        res_ng_d  = alu_ng;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[grant_id_q] = 1'b1;
        if (rsp_ready[grant_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      op_x_q       <= '0;
      op_y_q       <= '0;
      op_ctrl_q    <= CTRL_ZERO;
      res_out_q    <= '0;
      res_zr_q     <= 1'b0;
      res_ng_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      op_ctrl_q    <= op_ctrl_d;
      res_out_q    <= res_out_d;
      res_zr_q     <= res_zr_d;
      res_ng_q     <= res_ng_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_id_q;
  assign rsp_out  = res_out_q;
  assign rsp_zr   = res_zr_q;
  assign rsp_ng   = res_ng_q;

endmodule
